// File: rtl/video_pkg.sv
// video_pkg: shared types, constants and helpers for the RGB video pipeline.
// Point-operation filter additions: pointop_mode_t, POINTOP_LAT, luma weights,
// and the saturating channel-offset helpers reused by later filters.
package video_pkg;

    // Sideband coordinate widths
    localparam int VID_XW = 12;
    localparam int VID_YW = 12;

    // Point-operation filter
    typedef enum logic [2:0] {
        PM_BYP  = 3'd0,
        PM_INV  = 3'd1,
        PM_GRAY = 3'd2,
        PM_THR  = 3'd3,
        PM_OFS  = 3'd4
    } pointop_mode_t;

    localparam int POINTOP_LAT = 2;

    // ITU-R BT.601-style luma weights, scaled by 256
    localparam int LUMA_WR = 77;
    localparam int LUMA_WG = 150;
    localparam int LUMA_WB = 29;

    // Widest channel the shared helpers support; callers zero/sign-extend into it
    localparam int SAT_MAXW = 12;

    // Sideband bundle as carried through delay chains
    typedef struct packed {
        logic              de;
        logic              sof;
        logic              eol;
        logic [VID_XW-1:0] x;
        logic [VID_YW-1:0] y;
    } vid_sb_t;

    // Reserved encodings fall back to bypass
    function automatic pointop_mode_t pointop_decode(input logic [2:0] m);
        case (m)
            3'd1:    return PM_INV;
            3'd2:    return PM_GRAY;
            3'd3:    return PM_THR;
            3'd4:    return PM_OFS;
            default: return PM_BYP;
        endcase
    endfunction

    // c + ofs clamped to [0, 2^cw-1]; c is unsigned, ofs is two's complement
    function automatic logic [SAT_MAXW-1:0] sat_add(
        input logic        [SAT_MAXW-1:0] c,
        input logic signed [SAT_MAXW:0]   ofs,
        input int unsigned                cw
    );
        logic signed [SAT_MAXW+1:0] sum;
        logic signed [SAT_MAXW+1:0] top;
        sum = $signed({2'b00, c}) + $signed({ofs[SAT_MAXW], ofs});
        top = $signed((SAT_MAXW+2)'((32'd1 << cw) - 32'd1));
        if (sum[SAT_MAXW+1])
            return '0;
        else if (sum > top)
            return top[SAT_MAXW-1:0];
        else
            return sum[SAT_MAXW-1:0];
    endfunction

    // True when sat_add would have clamped
    function automatic logic sat_clip(
        input logic        [SAT_MAXW-1:0] c,
        input logic signed [SAT_MAXW:0]   ofs,
        input int unsigned                cw
    );
        logic signed [SAT_MAXW+1:0] sum;
        logic signed [SAT_MAXW+1:0] top;
        sum = $signed({2'b00, c}) + $signed({ofs[SAT_MAXW], ofs});
        top = $signed((SAT_MAXW+2)'((32'd1 << cw) - 32'd1));
        return sum[SAT_MAXW+1] || (sum > top);
    endfunction

endpackage

// File: rtl/vid_sideband_if.sv
// vid_sideband_if: per-pixel timing sideband shared by all pipeline stages.
interface vid_sideband_if;
    import video_pkg::*;

    logic              de;
    logic              sof;
    logic              eol;
    logic [VID_XW-1:0] x;
    logic [VID_YW-1:0] y;

    modport src  (output de, sof, eol, x, y);
    modport sink (input  de, sof, eol, x, y);

endinterface

// File: rtl/filt_luma.sv
// filt_luma: combinational luma Y = (77*R + 150*G + 29*B) >> 8 from a packed {R,G,B}.
// The weights sum to 256, so the result never exceeds 2^CW-1.
module filt_luma
    import video_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [3*CW-1:0] px,
    output logic [CW-1:0]   y
);

    logic [CW+9:0] r_w;
    logic [CW+9:0] g_w;
    logic [CW+9:0] b_w;
    logic [CW+9:0] sum;
    logic          unused_luma_bits;

    assign r_w = (CW+10)'(px[3*CW-1 -: CW]);
    assign g_w = (CW+10)'(px[2*CW-1 -: CW]);
    assign b_w = (CW+10)'(px[CW-1 -: CW]);

    assign sum = (CW+10)'(LUMA_WR) * r_w
               + (CW+10)'(LUMA_WG) * g_w
               + (CW+10)'(LUMA_WB) * b_w;

    assign y = sum[CW+7:8];

    // Headroom and fraction bits are dropped by design
    assign unused_luma_bits = ^{sum[CW+9:CW+8], sum[7:0]};

endmodule

// File: rtl/filt_pointop.sv
// filt_pointop: frame-synchronous per-pixel point operation (bypass, invert,
// grayscale, threshold, signed offset) with a two-cycle pipeline. Config is
// shadowed and only taken on an active start-of-frame pixel.
// Optional macro FILT_POINTOP_STATS_EN adds a per-frame clipped-channel counter
// for offset mode; without it stat_clip_cnt/stat_vld are tied low.
module filt_pointop
    import video_pkg::*;
#(
    parameter int CW     = 8,
    parameter int STAT_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3*CW-1:0]     px_in,
    vid_sideband_if.sink        sb_in,
    output logic [3*CW-1:0]     px_out,
    vid_sideband_if.src         sb_out,
    input  logic [2:0]          cfg_mode,
    input  logic [CW-1:0]       cfg_thr,
    input  logic [CW:0]         cfg_ofs,
    output logic [2:0]          act_mode,
    output logic [STAT_W-1:0]   stat_clip_cnt,
    output logic                stat_vld
);

    logic          load_cfg;
    pointop_mode_t act_mode_q;
    logic [CW-1:0] act_thr_q;
    logic [CW:0]   act_ofs_q;
    pointop_mode_t eff_mode;
    logic [CW-1:0] eff_thr;
    logic [CW:0]   eff_ofs;

    logic [CW-1:0] y_in;

    logic [3*CW-1:0] s1_px;
    logic [CW-1:0]   s1_y;
    pointop_mode_t   s1_mode;
    logic [CW-1:0]   s1_thr;
    logic [CW:0]     s1_ofs;

    vid_sb_t         sb_in_w;
    vid_sb_t         sb_dly [POINTOP_LAT];
    vid_sb_t         s1_sb;

    logic [3*CW-1:0] res;
    logic [3*CW-1:0] px_out_q;

    // The sof pixel itself already sees the incoming config
    assign load_cfg = sb_in.de & sb_in.sof;

    assign sb_in_w = {sb_in.de, sb_in.sof, sb_in.eol, sb_in.x, sb_in.y};
    assign s1_sb   = sb_dly[0];

    // Select the config that applies to the pixel entering S1
    always_comb begin
        eff_mode = act_mode_q;
        eff_thr  = act_thr_q;
        eff_ofs  = act_ofs_q;
        if (load_cfg) begin
            eff_mode = pointop_decode(cfg_mode);
            eff_thr  = cfg_thr;
            eff_ofs  = cfg_ofs;
        end
    end

    // Shadow config registers, updated only on an active sof
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_mode_q <= PM_BYP;
            act_thr_q  <= '0;
            act_ofs_q  <= '0;
        end else if (load_cfg) begin
            act_mode_q <= eff_mode;
            act_thr_q  <= eff_thr;
            act_ofs_q  <= eff_ofs;
        end
    end

    filt_luma #(
        .CW (CW)
    ) u_luma (
        .px (px_in),
        .y  (y_in)
    );

    // S1: capture pixel, its luma and the config it must be rendered with
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_px   <= '0;
            s1_y    <= '0;
            s1_mode <= PM_BYP;
            s1_thr  <= '0;
            s1_ofs  <= '0;
        end else begin
            s1_px   <= px_in;
            s1_y    <= y_in;
            s1_mode <= eff_mode;
            s1_thr  <= eff_thr;
            s1_ofs  <= eff_ofs;
        end
    end

    // Sideband delay chain, one entry per pipeline stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < POINTOP_LAT; i++)
                sb_dly[i] <= '0;
        end else begin
            sb_dly[0] <= sb_in_w;
            for (int i = 1; i < POINTOP_LAT; i++)
                sb_dly[i] <= sb_dly[i-1];
        end
    end

    // Mode result per channel; blanked pixels are forced to zero
    always_comb begin
        logic [CW-1:0] ch;
        logic [CW-1:0] thr_px;
        res    = '0;
        ch     = '0;
        thr_px = (s1_y >= s1_thr) ? {CW{1'b1}} : {CW{1'b0}};
        for (int i = 0; i < 3; i++) begin
            ch = s1_px[i*CW +: CW];
            case (s1_mode)
                PM_INV:  res[i*CW +: CW] = ~ch;
                PM_GRAY: res[i*CW +: CW] = s1_y;
                PM_THR:  res[i*CW +: CW] = thr_px;
                PM_OFS:  res[i*CW +: CW] = CW'(sat_add(SAT_MAXW'(ch),
                                               (SAT_MAXW+1)'($signed(s1_ofs)), CW));
                default: res[i*CW +: CW] = ch;
            endcase
        end
        if (!s1_sb.de)
            res = '0;
    end

    // S2: register the output pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            px_out_q <= '0;
        else
            px_out_q <= res;
    end

    assign px_out     = px_out_q;
    assign sb_out.de  = sb_dly[POINTOP_LAT-1].de;
    assign sb_out.sof = sb_dly[POINTOP_LAT-1].sof;
    assign sb_out.eol = sb_dly[POINTOP_LAT-1].eol;
    assign sb_out.x   = sb_dly[POINTOP_LAT-1].x;
    assign sb_out.y   = sb_dly[POINTOP_LAT-1].y;
    assign act_mode   = act_mode_q;

`ifdef FILT_POINTOP_STATS_EN
    logic [1:0]        clip_px;
    logic [STAT_W-1:0] clip_acc;
    logic [STAT_W:0]   acc_sum;
    logic [STAT_W-1:0] stat_cnt_q;
    logic              stat_vld_q;

    // Clipped channels of the pixel in S1 (offset mode, active pixels only)
    always_comb begin
        clip_px = '0;
        if (s1_sb.de && s1_mode == PM_OFS) begin
            for (int i = 0; i < 3; i++)
                clip_px = clip_px + 2'(sat_clip(SAT_MAXW'(s1_px[i*CW +: CW]),
                                                (SAT_MAXW+1)'($signed(s1_ofs)), CW));
        end
    end

    assign acc_sum = {1'b0, clip_acc} + (STAT_W+1)'(clip_px);

    // Frame counter: publish and restart on the loading sof, saturate otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_acc   <= '0;
            stat_cnt_q <= '0;
            stat_vld_q <= 1'b0;
        end else if (s1_sb.de && s1_sb.sof) begin
            stat_cnt_q <= clip_acc;
            stat_vld_q <= 1'b1;
            clip_acc   <= STAT_W'(clip_px);
        end else begin
            stat_vld_q <= 1'b0;
            clip_acc   <= acc_sum[STAT_W] ? {STAT_W{1'b1}} : acc_sum[STAT_W-1:0];
        end
    end

    assign stat_clip_cnt = stat_cnt_q;
    assign stat_vld      = stat_vld_q;
`else
    assign stat_clip_cnt = '0;
    assign stat_vld      = 1'b0;
`endif

endmodule

// File: tb/tb_filt_pointop.sv
// Directed bench for filt_pointop (CW = 8) with hand-computed expected pixels.
module tb_filt_pointop;
    import video_pkg::*;

    localparam int CW     = 8;
    localparam int STAT_W = 24;

    logic              clk;
    logic              rst_n;
    logic [3*CW-1:0]   px_in;
    logic [3*CW-1:0]   px_out;
    logic [2:0]        cfg_mode;
    logic [CW-1:0]     cfg_thr;
    logic [CW:0]       cfg_ofs;
    logic [2:0]        act_mode;
    logic [STAT_W-1:0] stat_clip_cnt;
    logic              stat_vld;

    int n_pass  = 0;
    int n_total = 0;

    vid_sideband_if sb_i ();
    vid_sideband_if sb_o ();

    filt_pointop #(
        .CW     (CW),
        .STAT_W (STAT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .px_in         (px_in),
        .sb_in         (sb_i),
        .px_out        (px_out),
        .sb_out        (sb_o),
        .cfg_mode      (cfg_mode),
        .cfg_thr       (cfg_thr),
        .cfg_ofs       (cfg_ofs),
        .act_mode      (act_mode),
        .stat_clip_cnt (stat_clip_cnt),
        .stat_vld      (stat_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [23:0] p, input logic de, input logic sof);
        px_in    = p;
        sb_i.de  = de;
        sb_i.sof = sof;
    endtask

    task automatic cfg(input logic [2:0] m, input logic [7:0] t, input logic [8:0] o);
        cfg_mode = m;
        cfg_thr  = t;
        cfg_ofs  = o;
    endtask

    initial begin
        rst_n = 1'b0;
        px_in = '0;
        sb_i.de = 1'b0; sb_i.sof = 1'b0; sb_i.eol = 1'b0; sb_i.x = '0; sb_i.y = '0;
        cfg(3'd0, 8'd0, 9'd0);
        #12;
        chk("rst_px",   px_out, 0);
        chk("rst_de",   sb_o.de, 0);
        chk("rst_act",  act_mode, 0);
        chk("rst_stat", stat_clip_cnt, 0);
        chk("rst_vld",  stat_vld, 0);
        step();
        rst_n = 1'b1;

        // No sof yet: bypass regardless of cfg_mode
        cfg(3'd1, 8'd0, 9'd0);
        pix(24'h0A141E, 1, 0); step();
        pix(24'h000000, 0, 0); step();
        chk("byp_pre_sof", px_out, 24'h0A141E);
        chk("byp_de",      sb_o.de, 1);
        chk("byp_act",     act_mode, 0);
        step();
        chk("blank", px_out, 0);

        // INV frame, mid-frame switch to GRAY is ignored
        pix(24'h007FFF, 1, 1); sb_i.x = 12'd5; step();
        chk("act_inv", act_mode, 1);
        cfg(3'd2, 8'd0, 9'd0);
        pix(24'h010203, 1, 0); sb_i.x = 12'd0; step();
        chk("inv_px",  px_out, 24'hFF8000);
        chk("inv_sof", sb_o.sof, 1);
        chk("inv_x",   sb_o.x, 5);
        pix(24'h000000, 0, 0); step();
        chk("inv_mid",     px_out, 24'hFEFDFC);
        chk("inv_mid_sof", sb_o.sof, 0);
        chk("inv_mid_act", act_mode, 1);

        // GRAY frame
        pix(24'hFFFFFF, 1, 1); step();
        pix(24'h6432C8, 1, 0); step();
        chk("gray_white", px_out, 24'hFFFFFF);
        chk("gray_act",   act_mode, 2);
        pix(24'h000000, 0, 0); step();
        chk("gray_mix", px_out, 24'h525252);

        // THR 100: equality is white
        cfg(3'd3, 8'd100, 9'd0);
        pix(24'h646464, 1, 1); step();
        pix(24'h636363, 1, 0); step();
        chk("thr_eq", px_out, 24'hFFFFFF);
        pix(24'h000000, 0, 0); step();
        chk("thr_below", px_out, 24'h000000);

        // THR 0 -> white; sof with de=0 must not reload
        cfg(3'd3, 8'd0, 9'd0);
        pix(24'h000000, 1, 1); step();
        cfg(3'd1, 8'd0, 9'd0);
        pix(24'h000000, 0, 1); step();
        chk("thr0", px_out, 24'hFFFFFF);
        pix(24'h000000, 1, 0); step();
        chk("sof_no_de_blank", px_out, 0);
        chk("sof_no_de_act",   act_mode, 3);
        pix(24'h000000, 0, 0); step();
        chk("sof_no_de_kept", px_out, 24'hFFFFFF);

        // OFS +50
        cfg(3'd4, 8'd0, 9'd50);
        pix(24'hDC0A00, 1, 1); step();
        pix(24'h000000, 1, 0); step();
        chk("ofs_pos", px_out, 24'hFF3C32);
        pix(24'h000000, 0, 0); step();
        chk("ofs_pos2", px_out, 24'h323232);

        // OFS -50
        cfg(3'd4, 8'd0, 9'h1CE);
        pix(24'h1EC832, 1, 1); step();
        pix(24'h000000, 0, 0); step();
        chk("ofs_neg", px_out, 24'h009600);
`ifdef FILT_POINTOP_STATS_EN
        chk("stat_pos_vld", stat_vld, 1);
        chk("stat_pos_cnt", stat_clip_cnt, 1);
`endif

        // OFS -256 clamps everything to 0
        cfg(3'd4, 8'd0, 9'h100);
        pix(24'hFFFFFF, 1, 1); step();
        pix(24'h000000, 0, 0); step();
        chk("ofs_min", px_out, 24'h000000);
`ifdef FILT_POINTOP_STATS_EN
        chk("stat_neg_cnt", stat_clip_cnt, 1);
`endif

        // Back-to-back sof: INV frame then reserved mode 5 (bypass)
        cfg(3'd1, 8'd0, 9'd0);
        pix(24'h000000, 1, 1); step();
        cfg(3'd5, 8'd0, 9'd0);
        pix(24'h010203, 1, 1); step();
        chk("b2b_inv", px_out, 24'hFFFFFF);
`ifdef FILT_POINTOP_STATS_EN
        chk("stat_min_cnt", stat_clip_cnt, 3);
`endif
        pix(24'h000000, 0, 0); step();
        chk("b2b_byp", px_out, 24'h010203);
        chk("b2b_act", act_mode, 0);
`ifndef FILT_POINTOP_STATS_EN
        chk("stat_tied_cnt", stat_clip_cnt, 0);
        chk("stat_tied_vld", stat_vld, 0);
`endif

        // Async reset mid-line
        cfg(3'd1, 8'd0, 9'd0);
        pix(24'h000000, 1, 1); step();
        pix(24'h000000, 1, 0); step();
        chk("pre_rst_px", px_out, 24'hFFFFFF);
        chk("pre_rst_de", sb_o.de, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_px",  px_out, 0);
        chk("rst_mid_de",  sb_o.de, 0);
        chk("rst_mid_act", act_mode, 0);
        pix(24'h000000, 0, 0);
        step(); step();
        rst_n = 1'b1;
        step(); step();
        chk("post_rst_px", px_out, 0);
        chk("post_rst_de", sb_o.de, 0);
        pix(24'h0A141E, 1, 0); step();
        pix(24'h000000, 0, 0); step();
        chk("post_rst_byp", px_out, 24'h0A141E);
        chk("post_rst_act", act_mode, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
